// File: rtl/rf_write_arbiter_pkg.sv
// rf_write_arbiter_pkg
//   Shared definitions for the register-file write arbiter slice.
//   - RF_DATA_W / RF_ADDR_W: default register data and address widths.
//   - REG_X0: the hard-wired zero register, which is never written or tracked.
//   - NUM_REGS: register count implied by the address width.
//   - write_src_e: which requester owns the write port in a given cycle.
package rf_write_arbiter_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int NUM_REGS  = 1 << RF_ADDR_W;

  localparam logic [RF_ADDR_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_MD   = 2'd2
  } write_src_e;

endpackage

// File: rtl/rf_write_arbiter_scoreboard.sv
// rf_scoreboard
//   One busy bit per architectural register, marking registers whose value
//   is still owed by the multi-cycle mul/div unit.
// Ports
//   CLK, RESET            clock, synchronous active-high reset
//   set_en, set_addr      MD op issued: mark set_addr busy (x0 ignored)
//   clr_en, clr_addr      MD result accepted: mark clr_addr free
//   rs1/rs2/rd_addr       ID-stage lookup addresses
//   busy_rs1/rs2/rd       current busy state of each lookup address
module rf_scoreboard
  import rf_write_arbiter_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              busy_rs1,
  output logic              busy_rs2,
  output logic              busy_rd
);

  localparam int NUM = 1 << ADDR_W;

  logic [NUM-1:0] busy;
  logic [NUM-1:0] busy_next;

  // The set is applied after the clear so that a new issue to a register
  // whose previous MD result retires in the same cycle stays busy.
  // Bit 0 is forced clear so x0 can never report a hazard.
  always_comb begin
    busy_next = busy;
    if (clr_en) begin
      busy_next[clr_addr] = 1'b0;
    end
    if (set_en) begin
      busy_next[set_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Lookups see the registered state only; a result retiring this cycle
  // still reads as busy until the next edge.
  assign busy_rs1 = busy[rs1_addr] && (rs1_addr != '0);
  assign busy_rs2 = busy[rs2_addr] && (rs2_addr != '0);
  assign busy_rd  = busy[rd_addr]  && (rd_addr  != '0);

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the register file's single write port between the pipeline
//   writeback (fixed priority, never stalls) and the mul/div unit (valid/ready).
//   Tracks outstanding MD destinations for ID-stage hazard checks and raises
//   a registered pipeline stall when MD has been blocked too long.
// Ports
//   CLK, RESET                      clock, synchronous active-high reset
//   WB_VALID/WB_RD/WB_DATA          pipeline writeback request
//   MD_VALID/MD_RD/MD_DATA          MD result, held until MD_READY
//   MD_READY                        MD result accepted this cycle
//   MD_ISSUE/MD_ISSUE_RD            MD op issued from ID this cycle
//   RS1_ADDR/RS2_ADDR/RD_ADDR       ID-stage hazard lookup addresses
//   BUSY_RS1/BUSY_RS2/BUSY_RD       lookup address awaits an MD result
//   STALL_PIPE                      freeze upstream, inject WB bubble
//   WRITE_ENABLE/ADDR/DATA          register file write port
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W       = RF_DATA_W,
  parameter int ADDR_W       = RF_ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WB_VALID,
  input  logic [ADDR_W-1:0] WB_RD,
  input  logic [DATA_W-1:0] WB_DATA,
  input  logic              MD_VALID,
  input  logic [ADDR_W-1:0] MD_RD,
  input  logic [DATA_W-1:0] MD_DATA,
  output logic              MD_READY,
  input  logic              MD_ISSUE,
  input  logic [ADDR_W-1:0] MD_ISSUE_RD,
  input  logic [ADDR_W-1:0] RS1_ADDR,
  input  logic [ADDR_W-1:0] RS2_ADDR,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic              BUSY_RS1,
  output logic              BUSY_RS2,
  output logic              BUSY_RD,
  output logic              STALL_PIPE,
  output logic              WRITE_ENABLE,
  output logic [ADDR_W-1:0] WRITE_ADDR,
  output logic [DATA_W-1:0] WRITE_DATA
);

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  write_src_e       src;
  logic             wb_real;
  logic             md_accept;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_next;

  // A writeback aimed at x0 is a no-op, so it does not claim the port.
  assign wb_real = WB_VALID && (WB_RD != '0);

  // Port owner: nothing during reset, otherwise WB beats MD.
  always_comb begin
    src = SRC_NONE;
    if (!RESET) begin
      if (wb_real) begin
        src = SRC_WB;
      end else if (MD_VALID) begin
        src = SRC_MD;
      end
    end
  end

  // Write port mux. An MD result for x0 is still handshaken so the MD unit
  // can retire it, but the register file sees no write.
  always_comb begin
    WRITE_ENABLE = 1'b0;
    WRITE_ADDR   = '0;
    WRITE_DATA   = '0;
    MD_READY     = 1'b0;
    case (src)
      SRC_WB: begin
        WRITE_ENABLE = 1'b1;
        WRITE_ADDR   = WB_RD;
        WRITE_DATA   = WB_DATA;
      end
      SRC_MD: begin
        MD_READY = 1'b1;
        if (MD_RD != '0) begin
          WRITE_ENABLE = 1'b1;
          WRITE_ADDR   = MD_RD;
          WRITE_DATA   = MD_DATA;
        end
      end
      default: begin
      end
    endcase
  end

  assign md_accept = MD_VALID && MD_READY;

  // Consecutive cycles a pending MD result has been refused, saturating at
  // the limit. Any acceptance or an idle MD unit restarts the count.
  always_comb begin
    if (!MD_VALID || md_accept) begin
      starve_cnt_next = '0;
    end else if (starve_cnt == CNT_MAX) begin
      starve_cnt_next = CNT_MAX;
    end else begin
      starve_cnt_next = starve_cnt + CNT_W'(1);
    end
  end

  // The stall is registered from the next count so it asserts the cycle
  // after the limit-th refusal and drops the cycle after acceptance.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      starve_cnt <= '0;
      STALL_PIPE <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_next;
      STALL_PIPE <= (starve_cnt_next == CNT_MAX);
    end
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .CLK      (CLK),
    .RESET    (RESET),
    .set_en   (MD_ISSUE),
    .set_addr (MD_ISSUE_RD),
    .clr_en   (md_accept),
    .clr_addr (MD_RD),
    .rs1_addr (RS1_ADDR),
    .rs2_addr (RS2_ADDR),
    .rd_addr  (RD_ADDR),
    .busy_rs1 (BUSY_RS1),
    .busy_rs2 (BUSY_RS2),
    .busy_rd  (BUSY_RD)
  );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
//   Directed bench for rf_write_arbiter. Each step drives inputs just after
//   the falling edge, pushes the expected port/scoreboard/stall values from a
//   small reference model onto a queue, and pops and compares them before the
//   next rising edge.
module tb_rf_write_arbiter;
  import rf_write_arbiter_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int LIMIT = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          WB_VALID;
  logic [AW-1:0] WB_RD;
  logic [DW-1:0] WB_DATA;
  logic          MD_VALID;
  logic [AW-1:0] MD_RD;
  logic [DW-1:0] MD_DATA;
  logic          MD_READY;
  logic          MD_ISSUE;
  logic [AW-1:0] MD_ISSUE_RD;
  logic [AW-1:0] RS1_ADDR;
  logic [AW-1:0] RS2_ADDR;
  logic [AW-1:0] RD_ADDR;
  logic          BUSY_RS1;
  logic          BUSY_RS2;
  logic          BUSY_RD;
  logic          STALL_PIPE;
  logic          WRITE_ENABLE;
  logic [AW-1:0] WRITE_ADDR;
  logic [DW-1:0] WRITE_DATA;

  typedef struct {
    string         tag;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          ready;
    logic          b1;
    logic          b2;
    logic          brd;
    logic          stall;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl_busy;
  int          mdl_cnt;
  logic        mdl_stall;
  int          errors = 0;
  int          checks = 0;

  always #5 CLK = ~CLK;

  rf_write_arbiter #(
    .DATA_W       (DW),
    .ADDR_W       (AW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .WB_VALID     (WB_VALID),
    .WB_RD        (WB_RD),
    .WB_DATA      (WB_DATA),
    .MD_VALID     (MD_VALID),
    .MD_RD        (MD_RD),
    .MD_DATA      (MD_DATA),
    .MD_READY     (MD_READY),
    .MD_ISSUE     (MD_ISSUE),
    .MD_ISSUE_RD  (MD_ISSUE_RD),
    .RS1_ADDR     (RS1_ADDR),
    .RS2_ADDR     (RS2_ADDR),
    .RD_ADDR      (RD_ADDR),
    .BUSY_RS1     (BUSY_RS1),
    .BUSY_RS2     (BUSY_RS2),
    .BUSY_RD      (BUSY_RD),
    .STALL_PIPE   (STALL_PIPE),
    .WRITE_ENABLE (WRITE_ENABLE),
    .WRITE_ADDR   (WRITE_ADDR),
    .WRITE_DATA   (WRITE_DATA)
  );

  // One comparison: counted, and reported with tag/field on mismatch.
  task automatic check1(input string tag, input string field,
                        input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  // Request inputs back to idle; lookup addresses are left as they are.
  task automatic idleInputs();
    RESET       = 1'b0;
    WB_VALID    = 1'b0;
    WB_RD       = '0;
    WB_DATA     = '0;
    MD_VALID    = 1'b0;
    MD_RD       = '0;
    MD_DATA     = '0;
    MD_ISSUE    = 1'b0;
    MD_ISSUE_RD = '0;
  endtask

  // Pop the oldest expectation and compare every observable output.
  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1 entries");
    end else begin
      e = exp_q.pop_front();
      check1(e.tag, "write_enable", 32'(WRITE_ENABLE), 32'(e.we));
      check1(e.tag, "write_addr",   32'(WRITE_ADDR),   32'(e.addr));
      check1(e.tag, "write_data",   WRITE_DATA,        e.data);
      check1(e.tag, "md_ready",     32'(MD_READY),     32'(e.ready));
      check1(e.tag, "busy_rs1",     32'(BUSY_RS1),     32'(e.b1));
      check1(e.tag, "busy_rs2",     32'(BUSY_RS2),     32'(e.b2));
      check1(e.tag, "busy_rd",      32'(BUSY_RD),      32'(e.brd));
      check1(e.tag, "stall_pipe",   32'(STALL_PIPE),   32'(e.stall));
    end
  endtask

  // Inputs for this cycle are already driven: predict the outputs, check
  // them mid-cycle, then advance the model to the state after the next edge.
  task automatic applyStimulus(input string tag);
    exp_t e;
    e.tag   = tag;
    e.we    = 1'b0;
    e.addr  = '0;
    e.data  = '0;
    e.ready = 1'b0;
    if (!RESET) begin
      if (WB_VALID && WB_RD != 0) begin
        e.we   = 1'b1;
        e.addr = WB_RD;
        e.data = WB_DATA;
      end else if (MD_VALID) begin
        e.ready = 1'b1;
        if (MD_RD != 0) begin
          e.we   = 1'b1;
          e.addr = MD_RD;
          e.data = MD_DATA;
        end
      end
    end
    e.b1    = mdl_busy[RS1_ADDR] && (RS1_ADDR != 0);
    e.b2    = mdl_busy[RS2_ADDR] && (RS2_ADDR != 0);
    e.brd   = mdl_busy[RD_ADDR]  && (RD_ADDR  != 0);
    e.stall = mdl_stall;
    exp_q.push_back(e);

    #2;
    checkOutput();

    if (RESET) begin
      mdl_busy  = '0;
      mdl_cnt   = 0;
      mdl_stall = 1'b0;
    end else begin
      if (MD_VALID && e.ready) mdl_busy[MD_RD] = 1'b0;
      if (MD_ISSUE && MD_ISSUE_RD != 0) mdl_busy[MD_ISSUE_RD] = 1'b1;
      if (MD_VALID && !e.ready) mdl_cnt = (mdl_cnt < LIMIT) ? mdl_cnt + 1 : LIMIT;
      else mdl_cnt = 0;
      mdl_stall = (mdl_cnt == LIMIT);
    end
  endtask

  initial begin
    idleInputs();
    RESET     = 1'b1;
    RS1_ADDR  = '0;
    RS2_ADDR  = '0;
    RD_ADDR   = '0;
    mdl_busy  = '0;
    mdl_cnt   = 0;
    mdl_stall = 1'b0;
    @(negedge CLK);

    // Idle after reset: no write, nothing busy, no stall.
    idleInputs(); applyStimulus("reset_idle");

    // WB and MD collide: WB writes x5, MD waits; then MD writes x7.
    @(negedge CLK); idleInputs();
    WB_VALID = 1'b1; WB_RD = 5'd5; WB_DATA = 32'h1111_0005;
    MD_VALID = 1'b1; MD_RD = 5'd7; MD_DATA = 32'h7777_0007;
    applyStimulus("wb_wins");
    @(negedge CLK); idleInputs();
    MD_VALID = 1'b1; MD_RD = 5'd7; MD_DATA = 32'h7777_0007;
    applyStimulus("md_after_wb");

    // WB to x0 leaves the port free for MD.
    @(negedge CLK); idleInputs();
    WB_VALID = 1'b1; WB_RD = 5'd0; WB_DATA = 32'h0BAD_0BAD;
    MD_VALID = 1'b1; MD_RD = 5'd9; MD_DATA = 32'hDEAD_BEEF;
    applyStimulus("wb_x0_md");

    // Scoreboard on x12: busy from the edge after issue until MD retires it.
    RS1_ADDR = 5'd12; RS2_ADDR = 5'd5; RD_ADDR = 5'd12;
    @(negedge CLK); idleInputs(); MD_ISSUE = 1'b1; MD_ISSUE_RD = 5'd12;
    applyStimulus("issue12");
    @(negedge CLK); idleInputs(); applyStimulus("busy12_a");
    @(negedge CLK); idleInputs(); applyStimulus("busy12_b");
    @(negedge CLK); idleInputs();
    MD_VALID = 1'b1; MD_RD = 5'd12; MD_DATA = 32'h0000_0C0C;
    applyStimulus("md12_done");
    @(negedge CLK); idleInputs(); applyStimulus("busy12_clear");

    // Issue and retire x12 in the same cycle: the new issue keeps it busy.
    @(negedge CLK); idleInputs(); MD_ISSUE = 1'b1; MD_ISSUE_RD = 5'd12;
    applyStimulus("reissue12");
    @(negedge CLK); idleInputs();
    MD_ISSUE = 1'b1; MD_ISSUE_RD = 5'd12;
    MD_VALID = 1'b1; MD_RD = 5'd12; MD_DATA = 32'h1212_1212;
    applyStimulus("issue_and_done");
    @(negedge CLK); idleInputs(); applyStimulus("set_wins");
    @(negedge CLK); idleInputs();
    MD_VALID = 1'b1; MD_RD = 5'd12; MD_DATA = 32'h2121_2121;
    applyStimulus("md12_final");
    @(negedge CLK); idleInputs(); applyStimulus("busy12_gone");

    // MD result for x0 is accepted without a register write.
    @(negedge CLK); idleInputs();
    MD_VALID = 1'b1; MD_RD = 5'd0; MD_DATA = 32'hFFFF_0000;
    applyStimulus("md_x0");

    // Starvation: MD refused every cycle until the stall appears and holds.
    for (int i = 0; i < LIMIT + 1; i++) begin
      @(negedge CLK); idleInputs();
      WB_VALID = 1'b1; WB_RD = 5'd4; WB_DATA = 32'hA000_0000 + 32'(i);
      MD_VALID = 1'b1; MD_RD = 5'd3; MD_DATA = 32'h0000_0333;
      applyStimulus($sformatf("starve%0d", i));
    end
    @(negedge CLK); idleInputs();
    MD_VALID = 1'b1; MD_RD = 5'd3; MD_DATA = 32'h0000_0333;
    applyStimulus("starve_release");
    @(negedge CLK); idleInputs(); applyStimulus("stall_clear");

    // Issue to x0 never marks anything busy.
    RS1_ADDR = 5'd0; RS2_ADDR = 5'd0; RD_ADDR = 5'd0;
    @(negedge CLK); idleInputs(); MD_ISSUE = 1'b1; MD_ISSUE_RD = 5'd0;
    applyStimulus("issue_x0");
    @(negedge CLK); idleInputs(); applyStimulus("x0_never_busy");

    // Reset while an MD result is pending clears the scoreboard and drops it.
    RS1_ADDR = 5'd20; RD_ADDR = 5'd20;
    @(negedge CLK); idleInputs(); MD_ISSUE = 1'b1; MD_ISSUE_RD = 5'd20;
    applyStimulus("issue20");
    @(negedge CLK); idleInputs();
    RESET = 1'b1;
    MD_VALID = 1'b1; MD_RD = 5'd20; MD_DATA = 32'h2020_2020;
    applyStimulus("reset_mid");
    @(negedge CLK); idleInputs(); applyStimulus("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
